// File: rtl/div_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_seq_pkg
//  Description : Shared definitions for the sequential divider: default
//                operand width and the controller state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package div_seq_pkg;

    // Default operand width in bits
    localparam int SIZE_DATA = 32;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : div_seq_pkg
`default_nettype wire

// File: rtl/div_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : div_seq_if
//  Description : Request/result bundle of the sequential divider.
//                master : drives start/dividend/divisor, observes results
//                slave  : the divider itself
//  Signals     : start     - begin a division (taken only when idle)
//                dividend  - unsigned numerator, sampled with start
//                divisor   - unsigned denominator, sampled with start
//                busy      - operation in progress or result being flagged
//                done      - one-cycle pulse, results valid from here on
//                quotient  - registered quotient
//                remainder - registered remainder
//                div_zero  - last accepted divisor was zero
//  Revision    : 1.0 - initial release
// ============================================================================
interface div_seq_if
    import div_seq_pkg::*;
#(
    parameter int SIZE = SIZE_DATA
) ();

    logic            start;
    logic [SIZE-1:0] dividend;
    logic [SIZE-1:0] divisor;
    logic            busy;
    logic            done;
    logic [SIZE-1:0] quotient;
    logic [SIZE-1:0] remainder;
    logic            div_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_zero
    );

endinterface : div_seq_if
`default_nettype wire

// File: rtl/div_seq_sub.sv
`default_nettype none
// ============================================================================
//  Module      : subN
//  Description : Combinational unsigned subtractor, SIZE bits wide.
//  Ports       : i_minuend    - SIZE-bit minuend
//                i_subtrahend - SIZE-bit subtrahend
//                o_difference - SIZE-bit difference (modulo 2^SIZE)
//                o_borrow     - 1 when i_minuend < i_subtrahend
//  Revision    : 1.0 - initial release
// ============================================================================
module subN #(
    parameter int SIZE = 33
) (
    input  wire logic [SIZE-1:0] i_minuend,
    input  wire logic [SIZE-1:0] i_subtrahend,
    output logic      [SIZE-1:0] o_difference,
    output logic                 o_borrow
);

    // One extra bit on each operand turns the carry-out into the borrow.
    assign {o_borrow, o_difference} = {1'b0, i_minuend} - {1'b0, i_subtrahend};

endmodule : subN
`default_nettype wire

// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : div_seq
//  Description : Sequential unsigned restoring divider. One quotient bit is
//                produced per clock; a nonzero division takes SIZE steps.
//                A zero divisor completes immediately with an all-ones
//                quotient, remainder = dividend and div_zero raised.
//  Ports       : clk   - clock, rising edge active
//                reset - asynchronous, active-low reset
//                bus   - div_seq_if slave modport (start/operands/results)
//  Revision    : 1.0 - initial release
// ============================================================================
module div_seq
    import div_seq_pkg::*;
#(
    parameter int SIZE = SIZE_DATA
) (
    input  wire logic  clk,
    input  wire logic  reset,
    div_seq_if.slave   bus
);

    localparam int c_CNT_W = (SIZE > 1) ? $clog2(SIZE) : 1;

    state_t              r_state;
    state_t              w_stateNext;

    // Partial remainder is stored SIZE bits wide: between steps it is always
    // below the divisor, so the extra top bit of the trial value is never
    // needed once a step has been resolved.
    logic [SIZE-1:0]     r_rem;
    logic [SIZE-1:0]     r_q;
    logic [SIZE-1:0]     r_d;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [SIZE-1:0]     r_quotient;
    logic [SIZE-1:0]     r_remainder;
    logic                r_divZero;

    logic [SIZE:0]       w_trial;
    logic [SIZE:0]       w_diff;
    logic                w_borrow;
    logic [SIZE-1:0]     w_rNext;
    logic [SIZE-1:0]     w_qNext;
    logic                w_lastStep;
    logic                w_accept;
    logic                w_zeroDiv;
    logic                w_unusedDiffMsb;

    // ------------------------------------------------------------------
    // Restoring step datapath
    // ------------------------------------------------------------------
    assign w_trial = {r_rem, r_q[SIZE-1]};

    subN #(
        .SIZE (SIZE + 1)
    ) u_sub (
        .i_minuend    (w_trial),
        .i_subtrahend ({1'b0, r_d}),
        .o_difference (w_diff),
        .o_borrow     (w_borrow)
    );

    // When the subtraction succeeds its result is below the divisor, so the
    // top difference bit is zero and can be dropped.
    assign w_unusedDiffMsb = w_diff[SIZE];

    assign w_rNext    = w_borrow ? w_trial[SIZE-1:0] : w_diff[SIZE-1:0];
    assign w_qNext    = {r_q[SIZE-2:0], ~w_borrow};
    assign w_lastStep = (r_cnt == c_CNT_W'(SIZE - 1));
    assign w_accept   = (r_state == IDLE) && bus.start;
    assign w_zeroDiv  = (bus.divisor == '0);

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        unique case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_stateNext = w_zeroDiv ? DONE : CALC;
                end
            end
            CALC: begin
                if (w_lastStep) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Working registers and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rem       <= '0;
            r_q         <= '0;
            r_d         <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_divZero   <= 1'b0;
        end else if (w_accept) begin
            r_rem <= '0;
            r_q   <= bus.dividend;
            r_d   <= bus.divisor;
            r_cnt <= '0;
            if (w_zeroDiv) begin
                // Result is known without iterating
                r_quotient  <= '1;
                r_remainder <= bus.dividend;
                r_divZero   <= 1'b1;
            end else begin
                r_divZero   <= 1'b0;
            end
        end else if (r_state == CALC) begin
            r_rem <= w_rNext;
            r_q   <= w_qNext;
            r_cnt <= r_cnt + c_CNT_W'(1);
            if (w_lastStep) begin
                // Publish the values produced by this final step
                r_quotient  <= w_qNext;
                r_remainder <= w_rNext;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.busy      = (r_state != IDLE);
    assign bus.done      = (r_state == DONE);
    assign bus.quotient  = r_quotient;
    assign bus.remainder = r_remainder;
    assign bus.div_zero  = r_divZero;

endmodule : div_seq
`default_nettype wire

// File: tb/tb_div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_seq
//  Description : Self-checking bench for div_seq (SIZE = 32). Directed vector
//                table plus hand-written sequences for start-while-busy and
//                reset during an operation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_seq;

    localparam int c_SIZE = 32;
    localparam int c_MAX_WAIT = 40;

    typedef struct {
        logic [31:0] dvd;
        logic [31:0] dvs;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;   // edges after the accepting edge until done is seen
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    vec_t vecs [10];

    div_seq_if #(.SIZE(c_SIZE)) bus ();

    div_seq #(
        .SIZE (c_SIZE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic checkZeroOutputs(input string tag);
        check({tag, ".busy"}, 32'(bus.busy), 32'd0);
        check({tag, ".done"}, 32'(bus.done), 32'd0);
        check({tag, ".quotient"}, bus.quotient, 32'd0);
        check({tag, ".remainder"}, bus.remainder, 32'd0);
        check({tag, ".div_zero"}, 32'(bus.div_zero), 32'd0);
    endtask

    // Waits for done starting from 'k' edges after the accepting edge.
    task automatic waitDone(input int kStart, output int k);
        k = kStart;
        while (!bus.done && k < c_MAX_WAIT) begin
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    // Entered at 1 time unit after a rising edge with the divider idle.
    // Leaves at 1 time unit after the edge that returns it to IDLE.
    task automatic runDiv(input vec_t v, input string tag);
        int   k;
        logic [31:0] qHeld;
        bus.start    = 1'b1;
        bus.dividend = v.dvd;
        bus.divisor  = v.dvs;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = 32'hDEAD_BEEF;
        bus.divisor  = 32'h0000_0003;
        check({tag, ".busy_accept"}, 32'(bus.busy), 32'd1);
        check({tag, ".dz_accept"}, 32'(bus.div_zero), 32'(v.dz));
        waitDone(0, k);
        check({tag, ".done_seen"}, 32'(bus.done), 32'd1);
        check({tag, ".latency"}, 32'(k), 32'(v.lat));
        check({tag, ".quotient"}, bus.quotient, v.q);
        check({tag, ".remainder"}, bus.remainder, v.r);
        check({tag, ".div_zero"}, 32'(bus.div_zero), 32'(v.dz));
        qHeld = bus.quotient;
        @(posedge clk);
        #1;
        check({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, ".busy_idle"}, 32'(bus.busy), 32'd0);
        check({tag, ".q_hold"}, bus.quotient, qHeld);
    endtask

    initial begin
        int   k;
        vec_t v;

        checks = 0;
        errors = 0;

        vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 32};
        vecs[1] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 32};
        vecs[2] = '{32'd3,          32'd10,         32'd0,          32'd3,          1'b0, 32};
        vecs[3] = '{32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 0};
        vecs[4] = '{32'd1000,       32'd10,         32'd100,        32'd0,          1'b0, 32};
        vecs[5] = '{32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0, 32};
        vecs[6] = '{32'd12345678,   32'd1000,       32'd12345,      32'd678,        1'b0, 32};
        vecs[7] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 32};
        vecs[8] = '{32'hDEAD_BEEF,  32'h0000_0010,  32'h0DEA_DBEE,  32'h0000_000F,  1'b0, 32};
        vecs[9] = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0, 32};

        // Reset state, checked before any clock edge and after a few edges
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        #3;
        checkZeroOutputs("reset_async");
        repeat (3) @(posedge clk);
        #1;
        checkZeroOutputs("reset_held");
        reset = 1'b1;

        // Vector table, each start issued in the first idle cycle after DONE
        for (int i = 0; i < 10; i++) begin
            runDiv(vecs[i], $sformatf("vec%0d", i));
        end

        // start pulsed at edge N+10 of 100/7 with 9/3 must be ignored
        bus.start    = 1'b1;
        bus.dividend = 32'd100;
        bus.divisor  = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        bus.start    = 1'b1;
        bus.dividend = 32'd9;
        bus.divisor  = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        waitDone(10, k);
        check("ignore.latency", 32'(k), 32'd32);
        check("ignore.quotient", bus.quotient, 32'd14);
        check("ignore.remainder", bus.remainder, 32'd2);
        check("ignore.div_zero", 32'(bus.div_zero), 32'd0);
        @(posedge clk);
        #1;

        // Reset between edges N+15 and N+16 of 100/7: outputs clear at once
        bus.start    = 1'b1;
        bus.dividend = 32'd100;
        bus.divisor  = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkZeroOutputs("midreset");
        k = 0;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk);
            #1;
            if (bus.done) k++;
        end
        check("midreset.no_done", 32'(k), 32'd0);
        reset = 1'b1;

        // First edge after release accepts a new division
        v = '{32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 32};
        runDiv(v, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_div_seq
`default_nettype wire
